// File: rtl/rhythm_score_keeper.sv
// rhythm_score_keeper: turns judged hit events into the score, combo and sound
// command that drive the 7-segment/piezo display block.
// Optional build macro SCORE_KEEPER_MAX_COMBO_EN adds o_Max_Combo, which holds the
// best combo reached since the last game start or reset.
// All outputs are registered. A hit shows on the outputs one edge after its strobe.
module rhythm_score_keeper #(
  parameter int PTS_PERFECT = 10,
  parameter int PTS_GREAT   = 5,
  parameter int PTS_GOOD    = 2,
  parameter int MULT_THRESH = 10,
  parameter int SCORE_MAX   = 9999,
  parameter int COMBO_MAX   = 99,
  parameter int SOUND_HOLD  = 2_500_000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Game_Start,
  input  logic        i_Game_End,
  input  logic        i_Hit_Valid,
  input  logic [1:0]  i_Hit_Grade,
  output logic [15:0] o_Score,
  output logic [7:0]  o_Combo,
  output logic [1:0]  o_Sound_Cmd,
  output logic        o_Playing
`ifdef SCORE_KEEPER_MAX_COMBO_EN
  ,
  output logic [7:0]  o_Max_Combo
`endif
);

  // Timer counts down from SOUND_HOLD-1, so the command stays on for SOUND_HOLD cycles.
  localparam int TMR_W = (SOUND_HOLD > 2) ? $clog2(SOUND_HOLD) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SOUND_HOLD - 1);

  localparam logic [1:0] SND_SILENT    = 2'b00;
  localparam logic [1:0] SND_MISS      = 2'b01;
  localparam logic [1:0] SND_HIT       = 2'b10;
  localparam logic [1:0] SND_MILESTONE = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_RESULT} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;

  logic       vld_p0;
  logic       miss_p0;
  logic [7:0] pts_base_p0;
  logic [8:0] pts_p0;
  logic [16:0] score_sum_p0;
  logic [15:0] score_nxt_p0;
  logic [7:0]  combo_nxt_p0;
  logic        milestone_p0;

  function automatic logic [15:0] sat_score(input logic [16:0] sum);
    if (sum > 17'(SCORE_MAX)) return 16'(SCORE_MAX);
    return sum[15:0];
  endfunction

  function automatic logic [7:0] sat_combo(input logic [8:0] sum);
    if (sum > 9'(COMBO_MAX)) return 8'(COMBO_MAX);
    return sum[7:0];
  endfunction

  function automatic logic is_milestone(input logic [7:0] c);
    return (c != 8'd0) && ((c % 8'd10) == 8'd0);
  endfunction

  // Evaluate the effect of the current hit against the pre-hit score and combo.
  always_comb begin
    vld_p0  = i_Hit_Valid && (state == ST_PLAY) && !i_Game_Start;
    miss_p0 = (i_Hit_Grade == 2'b00);
    case (i_Hit_Grade)
      2'b01:   pts_base_p0 = 8'(PTS_GOOD);
      2'b10:   pts_base_p0 = 8'(PTS_GREAT);
      2'b11:   pts_base_p0 = 8'(PTS_PERFECT);
      default: pts_base_p0 = 8'd0;
    endcase
    pts_p0 = (o_Combo >= 8'(MULT_THRESH)) ? {pts_base_p0, 1'b0} : {1'b0, pts_base_p0};
    score_sum_p0 = {1'b0, o_Score} + 17'(pts_p0);
    score_nxt_p0 = sat_score(score_sum_p0);
    combo_nxt_p0 = sat_combo({1'b0, o_Combo} + 9'd1);
    // A combo pinned at its ceiling does not re-trigger the milestone tone.
    milestone_p0 = (combo_nxt_p0 != o_Combo) && is_milestone(combo_nxt_p0);
  end

  // Game state, counters and the sound command/hold timer.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      o_Score     <= 16'd0;
      o_Combo     <= 8'd0;
      o_Sound_Cmd <= SND_SILENT;
      o_Playing   <= 1'b0;
      timer       <= '0;
`ifdef SCORE_KEEPER_MAX_COMBO_EN
      o_Max_Combo <= 8'd0;
`endif
    end else if (i_Game_Start) begin
      // Start wins over end and discards any hit on the same edge.
      state       <= ST_PLAY;
      o_Score     <= 16'd0;
      o_Combo     <= 8'd0;
      o_Sound_Cmd <= SND_SILENT;
      o_Playing   <= 1'b1;
      timer       <= '0;
`ifdef SCORE_KEEPER_MAX_COMBO_EN
      o_Max_Combo <= 8'd0;
`endif
    end else begin
      /* ---- stage p0 -> outputs ---- */
      if (vld_p0) begin
        timer <= TMR_LOAD;
        if (miss_p0) begin
          o_Combo     <= 8'd0;
          o_Sound_Cmd <= SND_MISS;
        end else begin
          o_Score     <= score_nxt_p0;
          o_Combo     <= combo_nxt_p0;
          o_Sound_Cmd <= milestone_p0 ? SND_MILESTONE : SND_HIT;
`ifdef SCORE_KEEPER_MAX_COMBO_EN
          if (combo_nxt_p0 > o_Max_Combo) o_Max_Combo <= combo_nxt_p0;
`endif
        end
      end else if (timer != '0) begin
        timer <= timer - TMR_W'(1);
      end else begin
        o_Sound_Cmd <= SND_SILENT;
      end
      // A hit on the same edge as game end is applied above before leaving PLAY.
      if ((state == ST_PLAY) && i_Game_End) begin
        state     <= ST_RESULT;
        o_Playing <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rhythm_score_keeper.sv
// Testbench for rhythm_score_keeper: scoreboard of expected outputs fed by a
// behavioural game model, directed scenarios followed by randomized play.
module tb_rhythm_score_keeper;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Game_Start = 1'b0;
  logic        i_Game_End = 1'b0;
  logic        i_Hit_Valid = 1'b0;
  logic [1:0]  i_Hit_Grade = 2'b00;
  logic [15:0] o_Score;
  logic [7:0]  o_Combo;
  logic [1:0]  o_Sound_Cmd;
  logic        o_Playing;
`ifdef SCORE_KEEPER_MAX_COMBO_EN
  logic [7:0]  o_Max_Combo;
`endif

  rhythm_score_keeper #(.SOUND_HOLD(HOLD)) dut (
    .i_Clk(clk),
    .i_Reset(i_Reset),
    .i_Game_Start(i_Game_Start),
    .i_Game_End(i_Game_End),
    .i_Hit_Valid(i_Hit_Valid),
    .i_Hit_Grade(i_Hit_Grade),
    .o_Score(o_Score),
    .o_Combo(o_Combo),
    .o_Sound_Cmd(o_Sound_Cmd),
    .o_Playing(o_Playing)
`ifdef SCORE_KEEPER_MAX_COMBO_EN
    ,
    .o_Max_Combo(o_Max_Combo)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int combo;
    int sound;
    int playing;
    int mx;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference model of the game: mode 0 idle, 1 playing, 2 results shown.
  int m_mode = 0;
  int m_score = 0;
  int m_combo = 0;
  int m_cmd = 0;
  int m_age = 1000;  // edges since the last sound command was issued
  int m_mx = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit start, input bit endg, input bit hv, input int grade);
    int pts;
    int nc;
    if (rst) begin
      m_mode = 0; m_score = 0; m_combo = 0; m_cmd = 0; m_age = 1000; m_mx = 0;
    end else if (start) begin
      m_mode = 1; m_score = 0; m_combo = 0; m_cmd = 0; m_age = 1000; m_mx = 0;
    end else begin
      if (m_age < 1000) m_age++;
      if (m_mode == 1 && hv) begin
        m_age = 0;
        if (grade == 0) begin
          m_combo = 0;
          m_cmd = 1;
        end else begin
          pts = (grade == 1) ? 2 : (grade == 2) ? 5 : 10;
          if (m_combo >= 10) pts = pts * 2;
          m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
          nc = (m_combo + 1 > 99) ? 99 : m_combo + 1;
          m_cmd = (nc != m_combo && nc % 10 == 0) ? 3 : 2;
          m_combo = nc;
          if (m_combo > m_mx) m_mx = m_combo;
        end
      end
      if (m_mode == 1 && endg) m_mode = 2;
    end
  endtask

  // Drive one cycle of inputs, push the expected post-edge outputs, wait past the edge.
  task automatic step(input bit rst, input bit start, input bit endg, input bit hv, input int grade);
    exp_t e;
    @(negedge clk);
    i_Reset = rst;
    i_Game_Start = start;
    i_Game_End = endg;
    i_Hit_Valid = hv;
    i_Hit_Grade = 2'(grade);
    model(rst, start, endg, hv, grade);
    e.score = m_score;
    e.combo = m_combo;
    e.sound = (m_age < HOLD) ? m_cmd : 0;
    e.playing = (m_mode == 1) ? 1 : 0;
    e.mx = m_mx;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: every edge presents a new output word; compare it with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("score", int'(o_Score), e.score);
      cmp("combo", int'(o_Combo), e.combo);
      cmp("sound", int'(o_Sound_Cmd), e.sound);
      cmp("playing", int'(o_Playing), e.playing);
`ifdef SCORE_KEEPER_MAX_COMBO_EN
      cmp("max_combo", int'(o_Max_Combo), e.mx);
`endif
    end
  end

  initial begin
    int r;
    int g;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    cmp("rst_score", int'(o_Score), 0);
    cmp("rst_combo", int'(o_Combo), 0);
    cmp("rst_sound", int'(o_Sound_Cmd), 0);
    cmp("rst_playing", int'(o_Playing), 0);

    // Three spaced perfect hits, then the tone expires.
    step(0, 1, 0, 0, 0);
    cmp("start_playing", int'(o_Playing), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 3);
      cmp("perf_score", int'(o_Score), (i + 1) * 10);
      cmp("perf_combo", int'(o_Combo), i + 1);
      cmp("perf_sound", int'(o_Sound_Cmd), 2);
      if (i < 2) idle(4);
    end
    idle(7);
    cmp("hold_sound_on", int'(o_Sound_Cmd), 2);
    idle(1);
    cmp("hold_sound_off", int'(o_Sound_Cmd), 0);

    // Ten goods reach the milestone, the eleventh is doubled.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);
    cmp("m10_combo", int'(o_Combo), 10);
    cmp("m10_score", int'(o_Score), 20);
    cmp("m10_sound", int'(o_Sound_Cmd), 3);
    step(0, 0, 0, 1, 1);
    cmp("m11_score", int'(o_Score), 24);
    cmp("m11_combo", int'(o_Combo), 11);
    cmp("m11_sound", int'(o_Sound_Cmd), 2);

    // Miss at combo 5.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    cmp("miss_combo", int'(o_Combo), 0);
    cmp("miss_score", int'(o_Score), 10);
    cmp("miss_sound", int'(o_Sound_Cmd), 1);
    step(0, 0, 0, 1, 1);
    cmp("after_miss_score", int'(o_Score), 12);

    // Best combo survives a miss.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 2);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2);
`ifdef SCORE_KEEPER_MAX_COMBO_EN
    cmp("max_combo_7", int'(o_Max_Combo), 7);
`endif

    // Saturation of both counters.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 600; i++) step(0, 0, 0, 1, 3);
    cmp("sat_score", int'(o_Score), 9999);
    cmp("sat_combo", int'(o_Combo), 99);
    step(0, 0, 0, 1, 3);
    cmp("sat_sound", int'(o_Sound_Cmd), 2);
    step(0, 0, 1, 0, 0);
    cmp("result_playing", int'(o_Playing), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    cmp("result_frozen_combo", int'(o_Combo), 99);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3);
    cmp("idle_score", int'(o_Score), 0);

    // Hit, end and start together: start wins.
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 3);
    step(0, 1, 1, 1, 3);
    cmp("all3_score", int'(o_Score), 0);
    cmp("all3_combo", int'(o_Combo), 0);
    cmp("all3_playing", int'(o_Playing), 1);

    // Reset mid-hold at score 40.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3);
    cmp("pre_rst_score", int'(o_Score), 40);
    step(1, 0, 0, 1, 3);
    cmp("mid_rst_score", int'(o_Score), 0);
    cmp("mid_rst_sound", int'(o_Sound_Cmd), 0);
    cmp("mid_rst_playing", int'(o_Playing), 0);

    // End with a hit on the same edge: hit applies.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 3);
    cmp("end_hit_score", int'(o_Score), 10);
    cmp("end_hit_playing", int'(o_Playing), 0);

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      g = (r == 0) ? 0 : (r < 3) ? 1 : (r < 6) ? 2 : 3;
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), g);
    end

    idle(2);
    repeat (3) @(posedge clk);
    #3;
    cmp("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
